proc_clk_gen: RTL

- Clock/enable generation stage that feeds the processor's divided-clock domain.
- Derives a programmable divided clock `clk_out` from fast `clk`, plus single-cycle edge strobes for enable-style logic and a stretched processor reset.
- Divide ratio can be changed at run time through a valid/ready port; changes apply only on period boundaries, so no runt pulses occur.
- Sits between the board clock/reset and the processor, imem, dmem and regfile.

---
 rtl/clk_gen_pkg.sv | 12 +
 rtl/proc_rst_hold.sv | 33 +++
 rtl/proc_clk_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared defaults and types for the processor clock generator.
// The clock-gating option in proc_clk_gen is enabled by defining PROC_CLK_GATE_EN.
package clk_gen_pkg;

  localparam int DIV_W_DEF        = 4;
  localparam int DEFAULT_HALF_DEF = 2;
  localparam int RST_HOLD_DEF     = 4;
  localparam int HOLD_W           = 8;

  typedef logic [DIV_W_DEF-1:0] half_t;

endpackage

// File: rtl/proc_rst_hold.sv
// Stretches the processor reset until a fixed number of divided-clock rises
// have occurred after the generator leaves reset.
module proc_rst_hold
  import clk_gen_pkg::*;
#(
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_stb,
  output logic proc_reset
);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_proc_reset;
  logic              w_last_rise;

  assign w_last_rise = (r_hold_cnt == HOLD_W'(RST_HOLD - 1));

  // Release lands on the same posedge as the RST_HOLD-th clk_out rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_cnt   <= '0;
      r_proc_reset <= 1'b1;
    end else if (rise_stb && r_proc_reset) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      if (w_last_rise) r_proc_reset <= 1'b0;
    end
  end

  assign proc_reset = r_proc_reset;

endmodule

// File: rtl/proc_clk_gen.sv
// Programmable divided clock with edge strobes, run-time half-period update and
// stretched processor reset. Define PROC_CLK_GATE_EN to add the run input.
module proc_clk_gen
  import clk_gen_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter int RST_HOLD     = RST_HOLD_DEF
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PROC_CLK_GATE_EN
  input  logic             run,
`endif
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             proc_reset,
  output logic [DIV_W-1:0] cur_half
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_half_q;
  logic [DIV_W-1:0] r_pend_half;
  logic             r_pend_v;
  logic             r_cfg_ready;
  logic             r_clk_out;

  logic [DIV_W-1:0] w_half_m1;
  logic [DIV_W-1:0] w_cfg_half;
  logic             w_tc;
  logic             w_stall;
  logic             w_rise;
  logic             w_fall;
  logic             w_xfer;

  assign w_half_m1  = r_half_q - DIV_W'(1);
  assign w_tc       = (r_cnt == w_half_m1);
  assign w_cfg_half = (cfg_half == '0) ? DIV_W'(1) : cfg_half;
  assign w_xfer     = cfg_valid && r_cfg_ready;

`ifdef PROC_CLK_GATE_EN
  // A suppressed rise parks the counter at terminal count until run returns.
  assign w_stall = w_tc && !r_clk_out && !run;
`else
  assign w_stall = 1'b0;
`endif

  assign w_rise = w_tc && !r_clk_out && !w_stall;
  assign w_fall = w_tc && r_clk_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_half_q    <= DIV_W'(DEFAULT_HALF);
      r_pend_half <= DIV_W'(DEFAULT_HALF);
      r_pend_v    <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      if (w_tc && !w_stall) begin
        r_cnt     <= '0;
        r_clk_out <= ~r_clk_out;
      end else if (!w_tc) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      // New half-period only takes effect at a rise, so a high phase never shortens.
      if (w_rise && r_pend_v) begin
        r_half_q    <= r_pend_half;
        r_cnt       <= '0;
        r_pend_v    <= 1'b0;
        r_cfg_ready <= 1'b1;
      end
      if (w_xfer) begin
        r_pend_half <= w_cfg_half;
        r_pend_v    <= 1'b1;
        r_cfg_ready <= 1'b0;
      end
    end
  end

  proc_rst_hold #(
    .RST_HOLD(RST_HOLD)
  ) u_rst_hold (
    .clk       (clk),
    .reset     (reset),
    .rise_stb  (w_rise),
    .proc_reset(proc_reset)
  );

  assign rise_stb  = w_rise && !reset;
  assign fall_stb  = w_fall && !reset;
  assign clk_out   = r_clk_out;
  assign cfg_ready = r_cfg_ready;
  assign cur_half  = r_half_q;

endmodule
